// File: rtl/pulse_train_sched_if.sv
// pulse_train_sched_if: start/config request and status bundle for the pulse-train scheduler.
// Carries the abort request only when PULSE_TRAIN_SCHED_ABORT_EN is defined.
interface pulse_train_sched_if #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
);
  logic             start;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_period;
  logic [NUM_W-1:0] cfg_count;
  logic             pulse_out;
  logic [NUM_W-1:0] pulse_idx;
  logic             busy;
  logic             done;
  logic             cfg_err;
`ifdef PULSE_TRAIN_SCHED_ABORT_EN
  logic             abort;
  modport master (output start, cfg_delay, cfg_width, cfg_period, cfg_count, abort,
                  input  pulse_out, pulse_idx, busy, done, cfg_err);
  modport slave  (input  start, cfg_delay, cfg_width, cfg_period, cfg_count, abort,
                  output pulse_out, pulse_idx, busy, done, cfg_err);
`else
  modport master (output start, cfg_delay, cfg_width, cfg_period, cfg_count,
                  input  pulse_out, pulse_idx, busy, done, cfg_err);
  modport slave  (input  start, cfg_delay, cfg_width, cfg_period, cfg_count,
                  output pulse_out, pulse_idx, busy, done, cfg_err);
`endif
endinterface

// File: rtl/pulse_train_sched.sv
// pulse_train_sched: emits count pulses of width cycles every period cycles after delay.
// Optional abort input enabled by defining PULSE_TRAIN_SCHED_ABORT_EN.
module pulse_train_sched #(
  parameter int    CNT_W    = 16,
  parameter int    NUM_W    = 8,
  parameter string POLARITY = "HIGH"
) (
  input logic clk,
  input logic rst_n,
  pulse_train_sched_if.slave bus
);
  localparam logic ACT = (POLARITY == "LOW") ? 1'b0 : 1'b1;
  typedef enum logic [2:0] {IDLE, DELAY, ACTIVE, GAP, DONE} state_t;
  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt, r_width, r_gap;
  logic [NUM_W-1:0] r_count, r_idx, w_idx;
  logic             r_pulse, r_busy, r_done, r_err, w_err, w_valid, w_abort, w_last;
  assign w_valid = bus.cfg_width != '0 && bus.cfg_period > bus.cfg_width && bus.cfg_count != '0;
  assign w_last  = r_cnt == '0;
`ifdef PULSE_TRAIN_SCHED_ABORT_EN
  // DONE already ends the train, so an abort there adds nothing
  assign w_abort = bus.abort && r_state != IDLE && r_state != DONE;
`else
  assign w_abort = 1'b0;
`endif
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_err   = 1'b0;
    if (w_abort) w_state = DONE;
    else
      case (r_state)
        IDLE: if (bus.start) begin
          w_err = !w_valid;
          if (w_valid) begin
            w_idx   = '0;
            w_state = bus.cfg_delay == '0 ? ACTIVE : DELAY;
            w_cnt   = bus.cfg_delay == '0 ? bus.cfg_width - 1'b1 : bus.cfg_delay - 1'b1;
          end
        end
        DELAY: begin
          w_state = w_last ? ACTIVE : DELAY;
          w_cnt   = w_last ? r_width - 1'b1 : r_cnt - 1'b1;
        end
        ACTIVE: begin
          w_state = !w_last ? ACTIVE : r_idx == r_count - 1'b1 ? DONE : GAP;
          w_cnt   = w_last ? r_gap - 1'b1 : r_cnt - 1'b1;
        end
        GAP: begin
          w_state = w_last ? ACTIVE : GAP;
          w_cnt   = w_last ? r_width - 1'b1 : r_cnt - 1'b1;
          w_idx   = w_last ? r_idx + 1'b1 : r_idx;
        end
        default: w_state = IDLE;
      endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_width <= '0;
      r_gap   <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_pulse <= ~ACT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_pulse <= w_state == ACTIVE ? ACT : ~ACT;
      r_busy  <= w_state != IDLE;
      r_done  <= w_state == DONE;
      r_err   <= w_err;
      if (r_state == IDLE && bus.start) begin
        r_width <= bus.cfg_width;
        r_gap   <= bus.cfg_period - bus.cfg_width;
        r_count <= bus.cfg_count;
      end
    end
  end
  assign bus.pulse_out = r_pulse;
  assign bus.pulse_idx = r_idx;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cfg_err   = r_err;
endmodule

// File: tb/tb_pulse_train_sched.sv
// tb_pulse_train_sched: table, directed and random stimulus for pulse_train_sched (HIGH and LOW
// polarity instances) checked every cycle against a timeline model of the pulse train.
`timescale 1ns/1ps
module tb_pulse_train_sched;
  localparam int CNT_W = 16;
  localparam int NUM_W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pulse_train_sched_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) hi_if ();
  pulse_train_sched_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) lo_if ();
  pulse_train_sched #(.CNT_W(CNT_W), .NUM_W(NUM_W), .POLARITY("HIGH")) u_hi (
    .clk(clk), .rst_n(rst_n), .bus(hi_if.slave));
  pulse_train_sched #(.CNT_W(CNT_W), .NUM_W(NUM_W), .POLARITY("LOW")) u_lo (
    .clk(clk), .rst_n(rst_n), .bus(lo_if.slave));
  assign lo_if.start      = hi_if.start;
  assign lo_if.cfg_delay  = hi_if.cfg_delay;
  assign lo_if.cfg_width  = hi_if.cfg_width;
  assign lo_if.cfg_period = hi_if.cfg_period;
  assign lo_if.cfg_count  = hi_if.cfg_count;
`ifdef PULSE_TRAIN_SCHED_ABORT_EN
  assign lo_if.abort = hi_if.abort;
`endif
  typedef struct {
    int d; int w; int p; int n; int exp_done; int exp_err;
  } vec_t;
  vec_t tbl[10];
  int checks = 0, errors = 0;
  int e_cnt = 0;
  int last_done_e = -1, last_err_e = -1;
  bit m_on = 1'b0, m_err = 1'b0;
  int m_e0 = 0, m_d = 0, m_w = 1, m_p = 2, m_n = 1, m_dend = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, e_cnt, got, exp);
    end
  endtask
  task automatic set_cfg(input int d, input int w, input int p, input int n);
    hi_if.cfg_delay  = CNT_W'(d);
    hi_if.cfg_width  = CNT_W'(w);
    hi_if.cfg_period = CNT_W'(p);
    hi_if.cfg_count  = NUM_W'(n);
  endtask
  task automatic rnd_cfg();
    set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
            int'($urandom_range(0, 9)), int'($urandom_range(0, 4)));
  endtask
  // Model: a train accepted at edge e0 occupies cycles 1..m_dend counted from e0; pulse k
  // covers cycles 1+d+k*p .. d+k*p+w; the done strobe sits in cycle m_dend.
  task automatic step();
    int c, cc, k, x_act, x_busy, x_done, x_idx;
    bit busy_prev, v;
    @(posedge clk);
    e_cnt++;
    m_err = 1'b0;
    if (!rst_n) m_on = 1'b0;
    else begin
      c = e_cnt - m_e0;
      busy_prev = m_on && c >= 1 && c <= m_dend;
      v = hi_if.cfg_width != 0 && hi_if.cfg_period > hi_if.cfg_width && hi_if.cfg_count != 0;
      if (!busy_prev && hi_if.start) begin
        if (v) begin
          m_on = 1'b1; m_e0 = e_cnt;
          m_d = int'(hi_if.cfg_delay); m_w = int'(hi_if.cfg_width);
          m_p = int'(hi_if.cfg_period); m_n = int'(hi_if.cfg_count);
          m_dend = 1 + m_d + (m_n - 1) * m_p + m_w;
        end else m_err = 1'b1;
      end
`ifdef PULSE_TRAIN_SCHED_ABORT_EN
      else if (busy_prev && hi_if.abort && c < m_dend) m_dend = c + 1;
`endif
    end
    @(negedge clk);
    c = e_cnt - m_e0 + 1;
    x_busy = (m_on && c <= m_dend) ? 1 : 0;
    x_done = (m_on && c == m_dend) ? 1 : 0;
    x_act = (m_on && c >= 1 + m_d && c < m_dend && ((c - 1 - m_d) % m_p) < m_w) ? 1 : 0;
    cc = c < m_dend - 1 ? c : m_dend - 1;
    k = (cc - 1 - m_d) / m_p;
    x_idx = (!m_on || cc < 1 + m_d) ? 0 : (k < m_n - 1 ? k : m_n - 1);
    chk("pulse_hi", 32'(hi_if.pulse_out), x_act);
    chk("pulse_lo", 32'(lo_if.pulse_out), 1 - x_act);
    chk("busy", 32'(hi_if.busy), x_busy);
    chk("done", 32'(hi_if.done), x_done);
    chk("cfg_err", 32'(hi_if.cfg_err), 32'(m_err));
    chk("pulse_idx", 32'(hi_if.pulse_idx), x_idx);
    chk("busy_lo", 32'(lo_if.busy), x_busy);
    if (hi_if.done === 1'b1) last_done_e = e_cnt;
    if (hi_if.cfg_err === 1'b1) last_err_e = e_cnt;
  endtask
  task automatic drain();
    for (int k = 0; k < 2000 && hi_if.busy !== 1'b0; k++) step();
    chk("drain_timeout", 32'(hi_if.busy), 0);
  endtask
  initial begin
    int s_e, dn, bl;
    hi_if.start = 1'b0;
`ifdef PULSE_TRAIN_SCHED_ABORT_EN
    hi_if.abort = 1'b0;
`endif
    set_cfg(0, 0, 0, 0);
    tbl[0] = '{2, 3, 5, 2, 11, 0};
    tbl[1] = '{0, 1, 2, 1, 2, 0};
    tbl[2] = '{1, 0, 5, 2, 0, 1};
    tbl[3] = '{0, 4, 4, 3, 0, 1};
    tbl[4] = '{0, 2, 5, 0, 0, 1};
    tbl[5] = '{1, 2, 4, 3, 12, 0};
    tbl[6] = '{0, 5, 6, 1, 6, 0};
    tbl[7] = '{3, 1, 7, 2, 12, 0};
    tbl[8] = '{0, 1, 2, 255, 510, 0};
    tbl[9] = '{5, 100, 300, 2, 406, 0};
    step(); step();
    chk("reset_pulse_lo", 32'(lo_if.pulse_out), 1);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      set_cfg(tbl[i].d, tbl[i].w, tbl[i].p, tbl[i].n);
      hi_if.start = 1'b1;
      s_e = e_cnt + 1;
      last_done_e = -1; last_err_e = -1;
      step();
      hi_if.start = 1'b0;
      rnd_cfg();
      drain();
      chk("tbl_done_cycle", last_done_e < 0 ? 0 : last_done_e - s_e + 1, tbl[i].exp_done);
      chk("tbl_err_cycle", last_err_e < 0 ? 0 : last_err_e - s_e + 1, tbl[i].exp_err);
      step();
    end
    // start held through consecutive trains, config swapped mid-train
    set_cfg(2, 3, 5, 2);
    hi_if.start = 1'b1;
    dn = 0; bl = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (k == 0) set_cfg(0, 1, 2, 1);
      dn += hi_if.done === 1'b1 ? 1 : 0;
      bl += hi_if.busy === 1'b0 ? 1 : 0;
    end
    chk("held_start_dones", dn, 5);
    chk("held_start_idle_cycles", bl, 5);
    hi_if.start = 1'b0;
    drain();
    step();
    // reset during the second pulse
    set_cfg(2, 3, 5, 2);
    hi_if.start = 1'b1;
    step();
    hi_if.start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("mid_pulse_active", 32'(hi_if.pulse_out), 1);
    chk("mid_pulse_idx", 32'(hi_if.pulse_idx), 1);
    rst_n = 1'b0;
    last_done_e = -1;
    step();
    chk("rst_pulse", 32'(hi_if.pulse_out), 0);
    chk("rst_busy", 32'(hi_if.busy), 0);
    chk("rst_idx", 32'(hi_if.pulse_idx), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) step();
    chk("rst_no_done", last_done_e >= 0 ? 1 : 0, 0);
`ifdef PULSE_TRAIN_SCHED_ABORT_EN
    set_cfg(2, 3, 5, 2);
    hi_if.start = 1'b1;
    step();
    hi_if.start = 1'b0;
    step(); step(); step();
    hi_if.abort = 1'b1;
    step();
    hi_if.abort = 1'b0;
    chk("abort_done", 32'(hi_if.done), 1);
    chk("abort_pulse_lo", 32'(lo_if.pulse_out), 1);
    step();
    chk("abort_idle", 32'(hi_if.busy), 0);
    hi_if.abort = 1'b1;
    step();
    hi_if.abort = 1'b0;
`endif
    for (int t = 0; t < 40; t++) begin
      rnd_cfg();
      hi_if.start = 1'b1;
      for (int k = int'($urandom_range(1, 3)); k > 0; k--) step();
      hi_if.start = 1'b0;
      for (int k = int'($urandom_range(0, 40)); k > 0; k--) begin
        if ($urandom_range(0, 9) < 2) rnd_cfg();
        hi_if.start = $urandom_range(0, 9) < 2;
`ifdef PULSE_TRAIN_SCHED_ABORT_EN
        hi_if.abort = $urandom_range(0, 99) < 3;
`endif
        rst_n = $urandom_range(0, 99) >= 2;
        step();
      end
      hi_if.start = 1'b0;
`ifdef PULSE_TRAIN_SCHED_ABORT_EN
      hi_if.abort = 1'b0;
`endif
      rst_n = 1'b1;
      drain();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", e_cnt);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pulse_train_sched.md
Name: pulse_train_sched

Overview:
- Programmable pulse-train scheduler. On a start request it emits `cfg_count` pulses on `pulse_out`.
- Each pulse is `cfg_width` cycles active, repeated every `cfg_period` cycles, after an initial `cfg_delay`.
- `pulse_out` drives the pulse-stretch / trigger-distribution logic downstream.
- Reports busy / done / config-error status to the register interface.

Parameters:
- `CNT_W`, 16, width of the delay, width and period counters.
- `NUM_W`, 8, width of the pulse-count field and the pulse index.
- `POLARITY`, "HIGH", active level of `pulse_out`: "HIGH" means active = 1, idle = 0; "LOW" means active = 0, idle = 1.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low; clock `clk`
- `start`  in  1  start request, sampled high for one or more cycles
- `cfg_delay`  in  CNT_W  cycles from start acceptance to first pulse
- `cfg_width`  in  CNT_W  active cycles per pulse
- `cfg_period`  in  CNT_W  cycles from one pulse's first active cycle to the next pulse's first active cycle
- `cfg_count`  in  NUM_W  number of pulses in the train
- `pulse_out`  out  1  registered pulse output, polarity per `POLARITY`
- `pulse_idx`  out  NUM_W  index (0-based) of the current or last pulse
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle strobe at train completion
- `cfg_err`  out  1  one-cycle strobe when a start is rejected

Behaviour:
- **Reset values:** `pulse_out` at idle level, `pulse_idx` = 0, `busy` = 0, `done` = 0, `cfg_err` = 0, state IDLE, all counters 0.
- **Reset mid-operation:** state returns to IDLE on the next edge and `pulse_out` goes idle at once. No `done` is issued.
- **FSM states:** IDLE, DELAY, ACTIVE, GAP, DONE.
- **IDLE:**
  - `start` = 1 latches all `cfg_*` into shadow registers; inputs are don't-care afterwards.
  - Validity check: `width` ≥ 1, `period` > `width`, `count` ≥ 1.
  - Invalid: `cfg_err` = 1 in the next cycle, stay IDLE.
  - Valid, `delay` = 0: go to ACTIVE.
  - Valid, `delay` > 0: go to DELAY.
- **DELAY:** lasts exactly `delay` cycles (down-counter), then ACTIVE.
- **ACTIVE:**
  - `pulse_out` is at the active level for exactly `width` cycles.
  - At the end, if `pulse_idx` = `count` - 1, go to DONE; else go to GAP.
- **GAP:**
  - `pulse_out` is idle for exactly `period` - `width` cycles.
  - `pulse_idx` increments on the transition GAP→ACTIVE.
- **DONE:** one cycle with `done` = 1 and `busy` = 1, then IDLE. `pulse_idx` holds its final value until the next accepted start, which clears it to 0.
- **Latency:** with `start` sampled at edge 0, the first active cycle is cycle 1 + `delay`.
- **Trailing gap:** the last pulse is not followed by a GAP phase.
- **Start while busy:** `start` is ignored in every non-IDLE state, including DONE. It is not queued.
- **Counter range:** maxima are 2^CNT_W - 1 cycles, with no wrap. `cfg_count` maximum is 2^NUM_W - 1.
- **Output registering:** all outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- **Macro:** `PULSE_TRAIN_SCHED_ABORT_EN`.
- **Defined:**
  - Adds input port `abort` (1 bit).
  - `abort` = 1 in any non-IDLE state forces DONE on the next edge: `pulse_out` goes idle in that cycle and `done` = 1 for that one cycle.
  - Abort has priority over the normal transitions.
  - `abort` in IDLE has no effect.
  - `abort` and `start` together in IDLE: `start` wins.
- **Not defined:** no `abort` port. The train always runs to completion or until reset.

Test Plan:
- **Basic two-pulse train:** `delay`=2, `width`=3, `period`=5, `count`=2, `start` at edge 0. Required: `pulse_out` active in cycles 3–5 and 8–10; `pulse_idx` = 1 from cycle 8; `done` in cycle 11; `busy` high in cycles 1–11; IDLE in cycle 12.
- **Minimum train:** `delay`=0, `width`=1, `period`=2, `count`=1. Required: active only in cycle 1, `done` in cycle 2, `pulse_idx` = 0.
- **Rejected configs:** `width`=0, then `period`=`width`=4, then `count`=0. Required: each gives `cfg_err` for one cycle, `busy` stays 0, `pulse_out` never active.
- **Start while busy:** `start` held high through a whole train, including the DONE cycle. Required: exactly one train; a new train is accepted only on the first IDLE cycle after DONE. `cfg_*` changes mid-train have no effect.
- **Reset mid-pulse:** `rst_n` low during ACTIVE of pulse 1. Required: `pulse_out` idle, `busy` = 0, `pulse_idx` = 0 next cycle, no `done`.
- **Inverted polarity and abort:** `POLARITY`="LOW" with the basic-train config. Required: idle level 1 from reset, active 0 in cycles 3–5 and 8–10. With the macro defined, `abort` at cycle 4 gives `pulse_out` = 1 and `done` = 1 in cycle 5, then IDLE in cycle 6.
